// File: rtl/cap_touch_scanner.sv
// Nine-pad RC touch scanner: charge, time each pad's discharge, threshold, debounce, latch press edges.
// Results appear with a one-cycle scan_done pulse the cycle after EVAL; no backpressure, press is sticky until cleared.
module cap_touch_scanner #(
    parameter int NUM_PADS      = 9,
    parameter int CHARGE_CYCLES = 64,
    parameter int TIMEOUT       = 1023,
    parameter int THRESHOLD     = 200,
    parameter int DEBOUNCE      = 3,
    parameter int CW            = $clog2(TIMEOUT + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [NUM_PADS-1:0] capacitive_sensors_in,
    output logic                capacitive_sensors_out,
    output logic [NUM_PADS-1:0] touched,
    output logic [NUM_PADS-1:0] press,
    input  logic [NUM_PADS-1:0] press_clear,
    output logic                scan_done,
    output logic                busy
);
    localparam int HW = $clog2(CHARGE_CYCLES + 1);
    localparam int DW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {S_IDLE, S_CHARGE, S_MEASURE, S_EVAL} state_t;

    state_t              state_q, state_d;
    logic [NUM_PADS-1:0] sync1_q, sync2_q;
    logic [HW-1:0]       chg_q, chg_d;
    logic [CW-1:0]       m_q, m_d;
    logic [NUM_PADS-1:0] cap_q, cap_d;
    logic [CW-1:0]       cnt_q [NUM_PADS];
    logic [CW-1:0]       cnt_d [NUM_PADS];
    logic [DW-1:0]       dbc_q [NUM_PADS];
    logic [DW-1:0]       dbc_d [NUM_PADS];
    logic [NUM_PADS-1:0] touched_q, touched_d;
    logic [NUM_PADS-1:0] press_q, press_d;
    logic [NUM_PADS-1:0] rise_q, rise_d;
    logic                done_q, done_d;
    logic [NUM_PADS-1:0] newcap;
    logic [NUM_PADS-1:0] clr_eff;

    always_comb begin
        state_d   = state_q;
        chg_d     = chg_q;
        m_d       = m_q;
        cap_d     = cap_q;
        cnt_d     = cnt_q;
        dbc_d     = dbc_q;
        touched_d = touched_q;
        rise_d    = '0;
        done_d    = 1'b0;
        newcap    = '0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_CHARGE;
                    chg_d   = '0;
                end
            end
            S_CHARGE: begin
                if (chg_q == HW'(CHARGE_CYCLES - 1)) begin
                    state_d = S_MEASURE;
                    m_d     = '0;
                    cap_d   = '0;
                end else begin
                    chg_d = chg_q + HW'(1);
                end
            end
            S_MEASURE: begin
                newcap = ~cap_q & ~sync2_q;
                cap_d  = cap_q | newcap;
                for (int i = 0; i < NUM_PADS; i++) begin
                    if (newcap[i]) cnt_d[i] = m_q;
                end
                if (&(cap_q | newcap)) begin
                    state_d = S_EVAL;
                end else if (m_q == CW'(TIMEOUT)) begin
                    for (int i = 0; i < NUM_PADS; i++) begin
                        if (!(cap_q[i] | newcap[i])) cnt_d[i] = CW'(TIMEOUT);
                    end
                    state_d = S_EVAL;
                end
                if (m_q != CW'(TIMEOUT)) m_d = m_q + CW'(1);
            end
            S_EVAL: begin
                for (int i = 0; i < NUM_PADS; i++) begin
                    if ((cnt_q[i] > CW'(THRESHOLD)) == touched_q[i]) begin
                        dbc_d[i] = '0;
                    end else if (dbc_q[i] == DW'(DEBOUNCE - 1)) begin
                        touched_d[i] = ~touched_q[i];
                        dbc_d[i]     = '0;
                    end else begin
                        dbc_d[i] = dbc_q[i] + DW'(1);
                    end
                end
                rise_d  = touched_d & ~touched_q;
                done_d  = 1'b1;
                chg_d   = '0;
                state_d = enable ? S_CHARGE : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A clear landing while a fresh rise is still on display loses to that rise.
    assign clr_eff = press_clear & ~(done_q ? rise_q : '0);
    assign press_d = (press_q & ~clr_eff) | rise_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            sync1_q   <= '0;
            sync2_q   <= '0;
            chg_q     <= '0;
            m_q       <= '0;
            cap_q     <= '0;
            cnt_q     <= '{default: '0};
            dbc_q     <= '{default: '0};
            touched_q <= '0;
            press_q   <= '0;
            rise_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= capacitive_sensors_in;
            sync2_q   <= sync1_q;
            chg_q     <= chg_d;
            m_q       <= m_d;
            cap_q     <= cap_d;
            cnt_q     <= cnt_d;
            dbc_q     <= dbc_d;
            touched_q <= touched_d;
            press_q   <= press_d;
            rise_q    <= rise_d;
            done_q    <= done_d;
        end
    end

    assign capacitive_sensors_out = (state_q == S_CHARGE);
    assign busy                   = (state_q != S_IDLE);
    assign touched                = touched_q;
    assign press                  = press_q;
    assign scan_done              = done_q;
endmodule

// File: doc/cap_touch_scanner.md
Name: cap_touch_scanner

Overview:
- Upstream input stage between the nine capacitive pads and the processor's sensor input.
- Each scan charges all pads through a shared drive line, releases it, and times each pad's discharge (an RC measurement).
- Discharge times are thresholded and debounced into a stable 9-bit touch vector.
- Rising edges of that vector set sticky "press" bits, which the processor reads and clears with a strobe. These are the mole hits.

Parameters:
NUM_PADS, 9, number of pads / width of the sense and touch vectors
CHARGE_CYCLES, 64, clock cycles the drive line is held high per scan (>=1)
TIMEOUT, 1023, maximum measure count; a pad not discharged by then is captured as TIMEOUT
THRESHOLD, 200, a pad is raw-touched when its captured count > THRESHOLD
DEBOUNCE, 3, consecutive disagreeing scans needed to flip a pad's debounced state (>=1)
CW, $clog2(TIMEOUT+1), measure counter width

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
enable  input  1  1 = scan continuously; 0 = finish current scan then idle
capacitive_sensors_in  input  NUM_PADS  raw asynchronous pad levels
capacitive_sensors_out  output  1  shared charge drive line
touched  output  NUM_PADS  debounced touch state
press  output  NUM_PADS  sticky rising-edge flags of touched
press_clear  input  NUM_PADS  per-bit clear strobe for press
scan_done  output  1  one-cycle pulse when touched/press reflect a new scan
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE; every output is 0.
  - Debounce counters, capture registers and synchronizers are cleared.
  - Reset mid-scan aborts immediately; there is no partial update of touched or press.
- Input synchronizer: two flops per pad. The measurement uses only the synchronized value s[i], which lags by 2 cycles.
- IDLE:
  - capacitive_sensors_out=0.
  - If enable=1, go to CHARGE with the charge counter cleared.
- CHARGE:
  - capacitive_sensors_out=1 for exactly CHARGE_CYCLES cycles, then MEASURE.
  - At MEASURE entry: measure counter m=0 and all captured flags clear.
- MEASURE:
  - capacitive_sensors_out=0; m increments by 1 each cycle, saturating at TIMEOUT.
  - For each uncaptured pad with s[i]==0 in a cycle, set cnt[i]=m and mark pad i captured. Multiple pads may capture in the same cycle.
  - A pad already low in the first MEASURE cycle captures 0.
  - Exit to EVAL when all pads are captured, or in the cycle m==TIMEOUT. In the latter case every uncaptured pad gets cnt=TIMEOUT.
  - The MEASURE length is therefore 1..TIMEOUT+1 cycles.
- EVAL (exactly 1 cycle):
  - raw[i] = (cnt[i] > THRESHOLD). Comparison is unsigned, CW bits.
  - If raw[i]==touched[i], dbc[i] is cleared.
  - Otherwise dbc[i] increments; when it reaches DEBOUNCE, touched[i] flips and dbc[i] is cleared.
  - New touched values are registered at the end of EVAL.
  - Next state is CHARGE if enable=1, else IDLE.
- scan_done:
  - Pulses 1 in the cycle after EVAL.
  - In that same cycle touched shows the updated value.
- press:
  - press[i] is set in the cycle touched[i] goes 0->1, i.e. coincident with scan_done.
  - press[i] is cleared by press_clear[i]=1.
  - Set and clear in the same cycle: set wins and press[i] stays 1.
  - touched falling never clears press.
- enable dropping mid-scan: the current scan completes normally, including the scan_done pulse, then the block idles.
- busy=1 in CHARGE, MEASURE and EVAL.

Test Plan (params CHARGE_CYCLES=4, TIMEOUT=31, THRESHOLD=10, DEBOUNCE=2):
- Reset/idle:
  - Stimulus: reset=0 for 3 cycles with enable=1, then reset=1, enable=0.
  - Required: all outputs 0, busy=0, capacitive_sensors_out never high.
- Untouched scan:
  - Stimulus: enable=1; all pads fall 3 cycles after the drive line falls.
  - Required: capacitive_sensors_out high for exactly 4 cycles; scan_done every scan; touched=0, press=0.
- Touch pad 4:
  - Stimulus: pad 4 falls 20 cycles after release, all other pads at 3 cycles.
  - Required: touched[4]=1 at the second scan_done, not the first; press=9'h010 in the same cycle.
- Timeout:
  - Stimulus: pad 0 held high permanently.
  - Required: MEASURE lasts 32 cycles; cnt[0]=31; touched[0]=1 after 2 scans.
- Debounce glitch:
  - Stimulus: pad 2 touched for one scan only.
  - Required: touched[2] stays 0; press[2] stays 0.
- Press handshake:
  - Stimulus 1: with press[4]=1, pulse press_clear=9'h010.
  - Required: press[4]=0 the next cycle; touched[4] unaffected.
  - Stimulus 2: press_clear[7]=1 in the same cycle touched[7] rises.
  - Required: press[7]=1 (set wins).
- Reset mid-MEASURE:
  - Stimulus: reset=0 during MEASURE, then released.
  - Required: IDLE, outputs 0, no scan_done pulse.
  - After release with enable=1: a fresh 4-cycle CHARGE.
